// File: rtl/mosfet_gate_monitor_pkg.sv
// Shared encodings for the gate monitor: fault types, leg history and leg indices.
package mosfet_gate_monitor_pkg;

  typedef enum logic [1:0] {
    FT_NONE  = 2'b00,
    FT_SHOOT = 2'b01,
    FT_DEAD  = 2'b10,
    FT_DEION = 2'b11
  } fault_type_e;

  typedef enum logic [1:0] {
    LAST_NONE = 2'b00,
    LAST_UP   = 2'b01,
    LAST_DOWN = 2'b10
  } last_on_e;

  localparam int unsigned NUM_LEGS  = 4;
  localparam int unsigned LEG_BUCK1 = 0;
  localparam int unsigned LEG_BUCK2 = 1;
  localparam int unsigned LEG_RES1  = 2;
  localparam int unsigned LEG_RES2  = 3;

  // Leg command encodings {upper, lower}
  localparam logic [1:0] LEG_OFF  = 2'b00;
  localparam logic [1:0] LEG_UP   = 2'b10;
  localparam logic [1:0] LEG_DOWN = 2'b01;
  localparam logic [1:0] LEG_BOTH = 2'b11;

endpackage

// File: rtl/mosfet_gate_monitor_checker.sv
// Per-leg tracker: remembers the last side turned on and how long the leg has
// been fully off, and flags shoot-through and dead-time violations.
module gate_leg_checker
  import mosfet_gate_monitor_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME = 16'd10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] leg_i,
  output logic       shoot_viol_o,
  output logic       dead_viol_o
);

  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_TIME);

  last_on_e         last_on_q, last_on_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic             short_gap;

  // History update and violation decode; a direct swap sees dead_cnt = 0.
  always_comb begin
    last_on_d    = last_on_q;
    dead_cnt_d   = dead_cnt_q;
    short_gap    = (dead_cnt_q < DEAD_LIM);
    shoot_viol_o = (leg_i == LEG_BOTH);
    dead_viol_o  = 1'b0;
    case (leg_i)
      LEG_OFF: begin
        if (dead_cnt_q != '1) dead_cnt_d = dead_cnt_q + CNT_W'(1);
      end
      LEG_UP: begin
        dead_viol_o = (last_on_q == LAST_DOWN) && short_gap;
        last_on_d   = LAST_UP;
        dead_cnt_d  = '0;
      end
      LEG_DOWN: begin
        dead_viol_o = (last_on_q == LAST_UP) && short_gap;
        last_on_d   = LAST_DOWN;
        dead_cnt_d  = '0;
      end
      default: begin
        dead_cnt_d = '0;
      end
    endcase
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_on_q  <= LAST_NONE;
      dead_cnt_q <= '0;
    end else begin
      last_on_q  <= last_on_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

endmodule

// File: rtl/mosfet_gate_monitor.sv
// Gate-command monitor: forwards leg/deion commands with one cycle of latency,
// kills all gates on the first violation, latches fault info, counts pulses.
module mosfet_gate_monitor
  import mosfet_gate_monitor_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME = 16'd10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       gate_buck1_in,
  input  logic [1:0]       gate_buck2_in,
  input  logic [1:0]       gate_res1_in,
  input  logic [1:0]       gate_res2_in,
  input  logic             gate_deion_in,
  input  logic             fault_clr,
  output logic [1:0]       gate_buck1,
  output logic [1:0]       gate_buck2,
  output logic [1:0]       gate_res1,
  output logic [1:0]       gate_res2,
  output logic             gate_deion,
  output logic             fault,
  output logic [1:0]       fault_type,
  output logic [3:0]       fault_leg,
  output logic [CNT_W-1:0] pulse_cnt
);

  logic [NUM_LEGS-1:0][1:0] leg_in;
  logic [NUM_LEGS-1:0]      shoot_viol, dead_viol, upper_on, deion_legs;
  logic                     viol;
  fault_type_e              viol_type;
  logic [3:0]               viol_leg;

  logic [NUM_LEGS-1:0][1:0] legs_q, legs_d;
  logic                     deion_q, deion_d;
  logic                     fault_q, fault_d;
  fault_type_e              ftype_q, ftype_d;
  logic [3:0]               fleg_q, fleg_d;
  logic [CNT_W-1:0]         pulse_q, pulse_d;
  logic                     deion_prev_q;

  assign leg_in = {gate_res2_in, gate_res1_in, gate_buck2_in, gate_buck1_in};

  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
    gate_leg_checker #(
      .DEAD_TIME (DEAD_TIME),
      .CNT_W     (CNT_W)
    ) u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .leg_i        (leg_in[g]),
      .shoot_viol_o (shoot_viol[g]),
      .dead_viol_o  (dead_viol[g])
    );
  end

  // Deion overlap detection and priority selection of this cycle's violation.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEGS; i++) upper_on[i] = leg_in[i][1];
    deion_legs = gate_deion_in ? upper_on : '0;
    viol_type  = FT_NONE;
    viol_leg   = '0;
    if (|shoot_viol) begin
      viol_type = FT_SHOOT;
      viol_leg  = shoot_viol;
    end else if (|dead_viol) begin
      viol_type = FT_DEAD;
      viol_leg  = dead_viol;
    end else if (|deion_legs) begin
      viol_type = FT_DEION;
      viol_leg  = deion_legs;
    end
    viol = (viol_type != FT_NONE);
  end

  // Fault latch, output gating and pulse counter next state.
  always_comb begin
    fault_d = fault_q;
    ftype_d = ftype_q;
    fleg_d  = fleg_q;
    // A new violation reloads only when not already faulted or when it
    // coincides with a clear; a clear alone wipes the info.
    if (viol) begin
      if (!fault_q || fault_clr) begin
        fault_d = 1'b1;
        ftype_d = viol_type;
        fleg_d  = viol_leg;
      end
    end else if (fault_clr) begin
      fault_d = 1'b0;
      ftype_d = FT_NONE;
      fleg_d  = '0;
    end
    legs_d  = (!fault_q && !viol) ? leg_in : '0;
    deion_d = !fault_q && !viol && gate_deion_in;
    pulse_d = pulse_q;
    if (gate_deion_in && !deion_prev_q && (pulse_q != '1)) pulse_d = pulse_q + CNT_W'(1);
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      legs_q       <= '0;
      deion_q      <= 1'b0;
      fault_q      <= 1'b0;
      ftype_q      <= FT_NONE;
      fleg_q       <= '0;
      pulse_q      <= '0;
      deion_prev_q <= 1'b0;
    end else begin
      legs_q       <= legs_d;
      deion_q      <= deion_d;
      fault_q      <= fault_d;
      ftype_q      <= ftype_d;
      fleg_q       <= fleg_d;
      pulse_q      <= pulse_d;
      deion_prev_q <= gate_deion_in;
    end
  end

  assign gate_buck1 = legs_q[LEG_BUCK1];
  assign gate_buck2 = legs_q[LEG_BUCK2];
  assign gate_res1  = legs_q[LEG_RES1];
  assign gate_res2  = legs_q[LEG_RES2];
  assign gate_deion = deion_q;
  assign fault      = fault_q;
  assign fault_type = ftype_q;
  assign fault_leg  = fleg_q;
  assign pulse_cnt  = pulse_q;

endmodule

// File: doc/mosfet_gate_monitor.md
# mosfet_gate_monitor

Sits between the discharge controller's gate commands and the gate-driver pins. It checks the four half-bridge legs and the deionisation switch every cycle for shoot-through, dead-time and deion-overlap violations. It forwards the commands to the pins with one cycle of latency and forces every gate off on the first violation. The fault is latched until software clears it, and the block also counts discharge cycles for the host.

## Interface
Parameters:
- DEAD_TIME, 16'd10, minimum cycles both switches of a leg must be off before the opposite switch turns on.
- CNT_W, 16, width of `pulse_cnt` and the per-leg dead counters.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- gate_buck1_in / gate_buck2_in / gate_res1_in / gate_res2_in  in  2 each  commanded leg state {upper, lower}.
- gate_deion_in  in  1  commanded deionisation switch.
- fault_clr  in  1  single-cycle request to clear the latched fault.
- gate_buck1 / gate_buck2 / gate_res1 / gate_res2  out  2 each  gated leg drive to pins.
- gate_deion  out  1  gated deion drive.
- fault  out  1  sticky fault flag.
- fault_type  out  2  01 shoot-through, 10 dead-time, 11 deion overlap, 00 none.
- fault_leg  out  4  legs involved in the first fault: bit0 buck1, bit1 buck2, bit2 res1, bit3 res2.
- pulse_cnt  out  CNT_W  rising edges of gate_deion_in; saturates at all-ones.

## Operation
- **Leg tracker.** There is one tracker per leg.
  - `last_on` takes one of three values: NONE, UP or DOWN. It resets to NONE.
  - `dead_cnt` counts cycles with the leg input at 00, saturating. It resets to 0 and returns to 0 on any on-state.
- **Leg input 11.** A shoot-through violation, irrespective of history.
- **Leg input 10 while `last_on` is DOWN** and the previous input was 00 with `dead_cnt < DEAD_TIME`: a dead-time violation. 01 while `last_on` is UP is the mirror case.
- **Direct 10↔01 with no 00 in between.** A dead-time violation, equivalent to `dead_cnt = 0`.
- **Re-entering the same side.** Turning on the same side as `last_on`, or turning on anything while `last_on` is NONE, is always legal.
- **Deion overlap.** `gate_deion_in = 1` while any leg's upper bit is 1 is a deion-overlap violation. `fault_leg` gets the bits of the offending legs.
- **Simultaneous violations in one cycle.** `fault_type` takes the highest-priority type: shoot-through > dead-time > deion. `fault_leg` is the OR of the legs carrying that type.
- **Fault latch.**
  - The first violation sets `fault`, `fault_type` and `fault_leg`.
  - Later violations do not overwrite them while `fault = 1`.
  - `fault_clr` clears all three only in a cycle with no new violation; a violation in the same cycle wins and reloads the new info.
- **Gating.** Each output register loads its input when `fault = 0` and no violation was detected this cycle. Otherwise it loads 00 (legs) or 0 (deion).
- **Trackers after a fault.** Trackers keep following the inputs while faulted, so no history reset is needed after a clear.
- **`pulse_cnt`.** Increments on a 0→1 edge of `gate_deion_in` whether or not a fault is present. It is cleared only by reset.

## Timing
- **Reset values.** All gate outputs 0; `fault` 0; `fault_type` 00; `fault_leg` 0000; `pulse_cnt` 0; previous-deion register 0.
- **Pass-through latency.** Input in cycle n appears on the output pins in cycle n+1.
- **Violation latency.** A violation on the input in cycle n gives, in cycle n+1, `fault = 1` with its info and all gate outputs at 0. The offending command never reaches the pins.
- **Clear latency.** `fault_clr` in cycle n gives `fault = 0` in cycle n+1. Gates then follow the cycle-n+1 input at n+2.
- **Dead-time boundary.** Exactly DEAD_TIME cycles of 00 before the opposite turn-on is legal; DEAD_TIME-1 cycles is a violation.
- **Reset mid-operation.** Asserting `rst_n` forces the outputs off asynchronously.

## Structure
- Shared package: the fault_type encodings (FT_NONE, FT_SHOOT, FT_DEAD, FT_DEION), the `last_on` encoding, and the leg index constants.
- One sub-module, `gate_leg_checker`, instantiated four times. Each instance holds `last_on` and `dead_cnt` and emits `shoot_viol` and `dead_viol`.
- The top level handles deion overlap, priority, the fault latch, output gating and `pulse_cnt`.

## Test plan
- **Dead time met.** buck1 goes 10 → 00 for 10 cycles → 01. Expect no fault and outputs equal to inputs delayed by 1.
- **Dead time short.** res1 goes 10 → 00 for 9 cycles → 01. Expect `fault = 1`, `fault_type = 10`, `fault_leg = 0100` one cycle later, with all outputs 0 from that cycle.
- **Shoot-through and direct swap together.** buck2 = 11 in the same cycle res2 goes directly 01 → 10. Expect `fault_type = 01`, `fault_leg = 0010`.
- **Deion overlap.** `gate_deion_in = 1` with buck1 = 10. Expect `fault_type = 11`, `fault_leg = 0001`.
- **Clear collides with violation.** `fault_clr` pulsed in the same cycle as a new dead-time violation on buck1. Expect `fault` to stay 1 with info reloaded to 10/0001. A later clean `fault_clr` gives `fault = 0` and gates following the inputs after 2 cycles.
- **Pulse count.** 70000 deion rising edges. Expect `pulse_cnt` to saturate at 16'hFFFF; asserting reset mid-stream gives immediate zeros on all outputs.
